// File: rtl/branch_resolver.sv
// branch_resolver: resolves conditional branches from ALU compare flags.
// Captures the N/Z/C/V flags of A-B in Execute, evaluates the branch
// condition in Memory and compares it with the Fetch prediction. On a
// mispredict it redirects Fetch and holds FlushPipe for FLUSH_CYCLES cycles.
// It also owns the 2-bit saturating branch history table behind PredTakenF.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   StallE, FlushE             Execute hold / squash (either blocks capture)
//   BranchValidE, BranchOpE    branch in Execute and its funct3
//   NE, ZE, CE, VE             compare flags (CE=1 means A <u B)
//   PCE, PCTargetE, PredTakenE branch PC, taken target, carried prediction
//   PCF / PredTakenF           Fetch PC lookup / BHT prediction
//   ResolveValidM, RedirectM,
//   RedirectPCM, FlushPipe     resolution results in Memory
module branch_resolver #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned BHT_IDX      = 6,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             BranchValidE,
  input  logic [2:0]       BranchOpE,
  input  logic             NE,
  input  logic             ZE,
  input  logic             CE,
  input  logic             VE,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic             PredTakenE,
  input  logic [WIDTH-1:0] PCF,
  output logic             PredTakenF,
  output logic             ResolveValidM,
  output logic             RedirectM,
  output logic [WIDTH-1:0] RedirectPCM,
  output logic             FlushPipe
);

  localparam int unsigned BHT_SIZE = 1 << BHT_IDX;
  localparam int unsigned CNT_W    = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;

  logic               valid_m;
  logic [2:0]         op_m;
  logic               n_m, z_m, c_m, v_m;
  logic [WIDTH-1:0]   target_m;
  logic [WIDTH-1:0]   pc4_m;
  logic               pred_m;
  logic [BHT_IDX-1:0] idx_m;

  logic [1:0]         bht [BHT_SIZE];

  logic               legal_e;
  logic               capture_e;
  logic               taken_m;
  logic               unused_pcf;

  // funct3 010/011 are not branches
  assign legal_e = (BranchOpE[2:1] != 2'b01);

  // Wrong-path branches (redirect in M or flush in progress) are dropped
  assign capture_e = BranchValidE & legal_e & ~StallE & ~FlushE &
                     (state == S_IDLE) & ~RedirectM;

  // Only the BHT index bits of the Fetch PC matter
  assign unused_pcf = ^{PCF[WIDTH-1:BHT_IDX+2], PCF[1:0]};

  // Execute -> Memory pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_m  <= 1'b0;
      op_m     <= 3'b000;
      n_m      <= 1'b0;
      z_m      <= 1'b0;
      c_m      <= 1'b0;
      v_m      <= 1'b0;
      target_m <= '0;
      pc4_m    <= '0;
      pred_m   <= 1'b0;
      idx_m    <= '0;
    end else begin
      valid_m <= capture_e;
      if (capture_e) begin
        op_m     <= BranchOpE;
        n_m      <= NE;
        z_m      <= ZE;
        c_m      <= CE;
        v_m      <= VE;
        target_m <= PCTargetE;
        pc4_m    <= PCE + WIDTH'(4);
        pred_m   <= PredTakenE;
        idx_m    <= PCE[BHT_IDX+1:2];
      end
    end
  end

  // Branch condition from the captured flags
  always_comb begin
    taken_m = 1'b0;
    case (op_m)
      3'b000:  taken_m = z_m;
      3'b001:  taken_m = ~z_m;
      3'b100:  taken_m = n_m ^ v_m;
      3'b101:  taken_m = ~(n_m ^ v_m);
      3'b110:  taken_m = c_m;
      3'b111:  taken_m = ~c_m;
      default: taken_m = 1'b0;
    endcase
  end

  // Resolution outputs
  always_comb begin
    ResolveValidM = valid_m;
    RedirectM     = valid_m & (taken_m != pred_m);
    RedirectPCM   = taken_m ? target_m : pc4_m;
  end

  // Branch history table: read is combinational and sees the pre-update value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < BHT_SIZE; i++) begin
        bht[BHT_IDX'(i)] <= 2'b01;
      end
    end else if (valid_m) begin
      if (taken_m) begin
        if (bht[idx_m] != 2'b11) bht[idx_m] <= bht[idx_m] + 2'b01;
      end else begin
        if (bht[idx_m] != 2'b00) bht[idx_m] <= bht[idx_m] - 2'b01;
      end
    end
  end

  assign PredTakenF = bht[PCF[BHT_IDX+1:2]][1];

  // Flush FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Flush FSM next state; the redirect cycle itself counts as the first flush cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (RedirectM && (FLUSH_CYCLES > 1)) begin
          state_n = S_FLUSH;
          cnt_n   = CNT_W'(FLUSH_CYCLES - 2);
        end
      end
      S_FLUSH: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Flush FSM outputs
  always_comb begin
    FlushPipe = 1'b0;
    if (RedirectM || (state == S_FLUSH)) FlushPipe = 1'b1;
  end

endmodule
